// File: rtl/regfile_writeback_pkg.sv
// Shared types and default sizes for the register-file write-back path.
package regfile_writeback_pkg;

  localparam int WB_DATA_W = 8;
  localparam int WB_ADDR_W = 2;
  localparam int WB_DEPTH  = 4;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_fifo.sv
// wb_fifo: generic synchronous FIFO with occupancy count; head is always visible.
// REGFILE_WB_FORWARD_EN exposes storage and read pointer for the forwarding search.
module wb_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [W-1:0]             push_data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o
`ifdef REGFILE_WB_FORWARD_EN
  ,
  output logic [DEPTH-1:0][W-1:0]  mem_o,
  output logic [$clog2(DEPTH)-1:0] rd_ptr_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    full, empty, do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
`ifdef REGFILE_WB_FORWARD_EN
  assign mem_o    = mem_q;
  assign rd_ptr_o = rd_ptr_q;
`endif

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-back: mem/ALU arbitration, retire FIFO and hazard scoreboard.
// Optional REGFILE_WB_FORWARD_EN adds a youngest-match forwarding port.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = WB_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_valid,
  input  logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_data,
  output logic                 mem_ready,
  input  logic                 alu_valid,
  input  logic [ADDR_W-1:0]    alu_addr,
  input  logic [DATA_W-1:0]    alu_data,
  output logic                 alu_ready,
  input  logic                 claim_valid,
  input  logic [ADDR_W-1:0]    claim_addr,
  output logic                 reg_wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic [2**ADDR_W-1:0] pending,
  output logic                 busy
`ifdef REGFILE_WB_FORWARD_EN
  ,
  input  logic [ADDR_W-1:0]    fwd_addr,
  output logic                 fwd_hit,
  output logic [DATA_W-1:0]    fwd_data
`endif
);

  localparam int NREG = 2**ADDR_W;
  localparam int EW   = ADDR_W + DATA_W;
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;

  logic [CW-1:0] count;
  logic [EW-1:0] head, push_data;
  logic          push;

  // Ready depends only on registered count, never on the same-cycle pop.
  assign mem_ready = (count != CW'(DEPTH));
  assign alu_ready = mem_ready && !mem_valid;
  assign push      = (mem_valid && mem_ready) || (alu_valid && alu_ready);
  assign push_data = mem_valid ? {mem_addr, mem_data} : {alu_addr, alu_data};

`ifdef REGFILE_WB_FORWARD_EN
  logic [DEPTH-1:0][EW-1:0] fifo_mem;
  logic [PW-1:0]            fifo_rd_ptr;
`endif

  wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (busy),
    .head_o      (head),
    .count_o     (count)
`ifdef REGFILE_WB_FORWARD_EN
    ,
    .mem_o       (fifo_mem),
    .rd_ptr_o    (fifo_rd_ptr)
`endif
  );

  // The register file never stalls: the head retires every non-empty cycle.
  assign busy                = (count != '0);
  assign reg_wr_en           = busy;
  assign {wr_addr, wr_data}  = busy ? head : '0;

  logic [NREG-1:0] pending_q, pending_d;

  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < NREG; i++) begin
      if (claim_valid && claim_addr == ADDR_W'(i))
        pending_d[i] = 1'b1;
      else if (reg_wr_en && wr_addr == ADDR_W'(i))
        pending_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  assign pending = pending_q;

`ifdef REGFILE_WB_FORWARD_EN
  // Walk oldest to youngest so the last match is the youngest.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = fifo_rd_ptr + PW'(k);
      if (CW'(k) < count && fifo_mem[idx][EW-1 -: ADDR_W] == fwd_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo_mem[idx][DATA_W-1:0];
      end
    end
  end
`endif

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side controller for the 4 x 8-bit register file. Accepts result writes from the ALU and the memory load path, arbitrates them, buffers them in a small FIFO and retires one per cycle onto the register file's write port (`reg_wr_en` / `wr_addr` / `wr_data`). A per-register scoreboard marks registers with an outstanding write, so issue logic can stall on read-after-write hazards.

## Interface
- `DATA_W`, default 8: register data width.
- `ADDR_W`, default 2: register address width; 2**ADDR_W registers.
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `mem_valid` in 1: memory load result valid.
- `mem_addr` in ADDR_W: destination register of the load.
- `mem_data` in DATA_W: load data.
- `mem_ready` out 1: memory result accepted this cycle when high with `mem_valid`.
- `alu_valid` in 1: ALU result valid.
- `alu_addr` in ADDR_W: ALU destination register.
- `alu_data` in DATA_W: ALU data.
- `alu_ready` out 1: ALU result accepted this cycle when high with `alu_valid`.
- `claim_valid` in 1: issue logic reserves a destination register.
- `claim_addr` in ADDR_W: register being reserved.
- `reg_wr_en` out 1: to register file write enable.
- `wr_addr` out ADDR_W: to register file write address.
- `wr_data` out DATA_W: to register file write data.
- `pending` out 2**ADDR_W: scoreboard; bit i set means register i has an outstanding write.
- `busy` out 1: FIFO non-empty.

## Operation
- FIFO of DEPTH entries {addr, data}, with write/read pointers and a count register.
- Arbitration uses fixed priority: memory over ALU.
  - `mem_ready = (count != DEPTH)`.
  - `alu_ready = (count != DEPTH) && !mem_valid`.
  - At most one enqueue per cycle.
- Drain: the register file never stalls, so the head entry is popped every cycle the FIFO is non-empty.
  - `reg_wr_en = busy`.
  - `wr_addr` / `wr_data` = head entry when busy, else 0.
  - These outputs are driven only from FIFO flops; there is no combinational path from any input.
- Simultaneous enqueue and pop: count is unchanged. This is legal even when count == DEPTH is reached on the same edge; ready is computed from the registered count only.
- FIFO pointers wrap modulo DEPTH.
- Scoreboard, per register i:
  - Set when `claim_valid && claim_addr == i`.
  - Cleared when `reg_wr_en && wr_addr == i`.
  - A set and a clear on the same register in the same cycle resolve to set (the new claim wins).
  - A write to an unclaimed register is legal; the bit stays 0.
- Order is preserved: entries retire in acceptance order, so two writes to the same register land oldest-first.

## Timing
- Reset values: FIFO empty, count 0, `pending` = 0, `reg_wr_en` = 0, `wr_addr` = 0, `wr_data` = 0, `busy` = 0, `mem_ready` = 1, `alu_ready` = 1.
- Reset asserted mid-operation discards all queued writes and clears the scoreboard immediately (asynchronous).
- Latency:
  - A request accepted at edge N presents `reg_wr_en` = 1 during cycle N..N+1 (when the FIFO was empty).
  - The register file captures it at edge N+1.
  - The value is readable on `rs*_data` after edge N+1.
- Throughput is one write per cycle sustained.
- A `pending` change is visible the cycle after the claim or retire edge.

## Configuration
- `REGFILE_WB_FORWARD_EN` adds ports `fwd_addr` (in, ADDR_W), `fwd_hit` (out, 1) and `fwd_data` (out, DATA_W).
  - These are combinational from `fwd_addr` and FIFO state.
  - `fwd_hit` = 1 if any valid FIFO entry (including the head being written this cycle) targets `fwd_addr`.
  - `fwd_data` = data of the youngest such entry; 0 when `fwd_hit` = 0.
- Without the macro the ports are absent and there is no search logic.

## Structure
- The shared package holds:
  - the `wb_entry_t` struct {addr, data};
  - default constants `WB_DATA_W` = 8, `WB_ADDR_W` = 2, `WB_DEPTH` = 4.
- One sub-module, `wb_fifo` (generic sync FIFO with count, full/empty), instantiated once. Arbitration, scoreboard and forwarding stay in the top level.

## Test plan
- Reset then idle -> all outputs at reset values; `pending` = 4'b0000.
- Single ALU write addr 2, data 0x5A at edge N -> `reg_wr_en` = 1, `wr_addr` = 2, `wr_data` = 0x5A for exactly one cycle after N; `busy` drops the next cycle.
- `mem_valid` and `alu_valid` together (mem: addr 1, 0x11; ALU: addr 3, 0x33) -> `alu_ready` = 0; mem write retires first; the ALU write retires once presented again the next cycle.
- Fill beyond capacity: enqueue on 5 back-to-back cycles with DEPTH = 4 and drain active -> no loss, count never exceeds 4, writes retire in order, `mem_ready` never low while drain keeps pace. Inject the same 5 writes after reset with `reg_wr_en` observed -> 5 writes in order.
- Claim addr 0 at edge N, write addr 0 retiring in the same cycle as a new claim of addr 0 -> `pending[0]` stays 1; a later write of addr 0 with no claim clears it.
- Assert reset with 3 entries queued -> `reg_wr_en` drops immediately; none of the 3 entries is written after reset release. With `REGFILE_WB_FORWARD_EN`: queue addr 1 = 0x10 then addr 1 = 0x20 -> `fwd_addr` = 1 gives hit = 1, data = 0x20.
